// File: rtl/vecmat_seq_ctrl.sv
// vecmat_seq_ctrl: sequential 1xN by NxM vector-matrix product.
// One row of M multipliers is reused over N cycles. Weight rows come from an
// external synchronous memory (data valid one cycle after row_rd), and per-column
// sums accumulate modulo 2^BW_OUT. The finished row is offered on a valid/ready port.
module vecmat_seq_ctrl #(
   parameter int N      = 4,
   parameter int M      = 4,
   parameter int BW     = 16,
   parameter int BW_OUT = 32,
   parameter int AW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N*BW-1:0]       vectorA_bus,
   input  logic                  abort,
   output logic                  row_rd,
   output logic [AW-1:0]         row_addr,
   input  logic [M*BW-1:0]       row_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [M*BW_OUT-1:0]   result_bus,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                   state, state_nxt;
   logic [AW-1:0]            cnt;
   logic [AW-1:0]            k_d;
   logic                     rd_d;
   logic                     accept;
   logic                     kill;
   logic signed [BW-1:0]     a_reg [N];
   logic signed [BW_OUT-1:0] acc   [M];
   logic signed [BW-1:0]     a_sel;

   assign accept = (state == IDLE) && in_valid;
   assign kill   = (state != IDLE) && abort;
   assign a_sel  = a_reg[k_d];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake/strobe outputs; abort wins over every other exit.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      row_rd    = 1'b0;
      out_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            row_rd = !abort;
            if (abort)                           state_nxt = IDLE;
            else if (cnt == AW'(N - 1))          state_nxt = DRAIN;
         end
         DRAIN: begin
            state_nxt = abort ? IDLE : DONE;
         end
         DONE: begin
            // An aborted result is discarded, so it is never offered as valid.
            out_valid = !abort;
            if (abort)          state_nxt = IDLE;
            else if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign row_addr = (state == RUN) ? cnt : '0;

   // Row counter: counts through RUN, parked at zero everywhere else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  cnt <= '0;
      else if (state == RUN && state_nxt == RUN)   cnt <= cnt + 1'b1;
      else                                         cnt <= '0;
   end

   // Read pipeline: remembers which row the memory is returning this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_d <= 1'b0;
         k_d  <= '0;
      end else begin
         rd_d <= row_rd;
         k_d  <= cnt;
      end
   end

   genvar gi;

   // Input vector latch: captured only at the accept edge.
   generate
      for (gi = 0; gi < N; gi++) begin : g_a
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      a_reg[gi] <= '0;
            else if (accept) a_reg[gi] <= vectorA_bus[(N-gi)*BW-1 -: BW];
         end
      end
   endgenerate

   // Per-column multiply-accumulate lane.
   generate
      for (gi = 0; gi < M; gi++) begin : g_col
         logic signed [BW-1:0]     w_elem;
         logic signed [2*BW-1:0]   prod;
         logic signed [BW_OUT-1:0] prod_ext;

         assign w_elem = row_data[(M-gi)*BW-1 -: BW];
         assign prod   = a_sel * w_elem;

         if (BW_OUT > 2*BW) begin : g_sext
            assign prod_ext = {{(BW_OUT-2*BW){prod[2*BW-1]}}, prod};
         end else if (BW_OUT == 2*BW) begin : g_same
            assign prod_ext = prod;
         end else begin : g_trunc
            assign prod_ext = prod[BW_OUT-1:0];
         end

         // Clearing (accept or abort) takes priority over a pending row.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)              acc[gi] <= '0;
            else if (kill || accept) acc[gi] <= '0;
            else if (rd_d)           acc[gi] <= acc[gi] + prod_ext;
         end

         assign result_bus[(M-gi)*BW_OUT-1 -: BW_OUT] = (state == DONE) ? acc[gi] : '0;
      end
   endgenerate

endmodule

// File: tb/tb_vecmat_seq_ctrl.sv
// Directed bench for vecmat_seq_ctrl (N=M=4, BW=16, BW_OUT=32) with a
// synchronous weight-memory model.
module tb_vecmat_seq_ctrl;
   localparam int N = 4, M = 4, BW = 16, BW_OUT = 32, AW = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic [N*BW-1:0]     vectorA_bus;
   logic                abort;
   logic                row_rd;
   logic [AW-1:0]       row_addr;
   logic [M*BW-1:0]     row_data;
   logic                out_valid;
   logic                out_ready;
   logic [M*BW_OUT-1:0] result_bus;
   logic                busy;

   int vectors = 0;
   int miscompares = 0;

   logic [M*BW-1:0] wmem [N];
   int              addr_log [8];
   int              addr_n;

   vecmat_seq_ctrl #(.N(N), .M(M), .BW(BW), .BW_OUT(BW_OUT), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .vectorA_bus(vectorA_bus), .abort(abort), .row_rd(row_rd), .row_addr(row_addr),
      .row_data(row_data), .out_valid(out_valid), .out_ready(out_ready),
      .result_bus(result_bus), .busy(busy)
   );

   always #5 clk = ~clk;

   // Synchronous weight memory: data appears the cycle after the strobe.
   always @(posedge clk) if (row_rd) row_data <= wmem[row_addr];

   function automatic logic [63:0] pk16(input int e0, input int e1, input int e2, input int e3);
      return {16'(e0), 16'(e1), 16'(e2), 16'(e3)};
   endfunction

   function automatic logic [127:0] pk32(input int e0, input int e1, input int e2, input int e3);
      return {32'(e0), 32'(e1), 32'(e2), 32'(e3)};
   endfunction

   task automatic load_identity();
      wmem[0] = pk16(1, 0, 0, 0);
      wmem[1] = pk16(0, 1, 0, 0);
      wmem[2] = pk16(0, 0, 1, 0);
      wmem[3] = pk16(0, 0, 0, 1);
   endtask

   // Accept one vector (caller ensures IDLE) and wait for out_valid; lat is the
   // edge count from the accept edge, -1 if the bound expires.
   task automatic run_vec(input logic [63:0] a, output logic [127:0] res, output int lat);
      addr_n = 0;
      lat = -1;
      vectorA_bus = a;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectorA_bus = {$urandom, $urandom};
      if (row_rd) begin addr_log[addr_n] = int'(row_addr); addr_n++; end
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (row_rd && addr_n < 8) begin addr_log[addr_n] = int'(row_addr); addr_n++; end
         if (out_valid) begin lat = k; break; end
      end
      res = result_bus;
      $display("txn A=%h result=%h latency=%0d", a, res, lat);
   endtask

   task automatic handshake();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
      vectorA_bus = '0; row_data = '0;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
      vectors++; if (row_rd !== 1'b0 || row_addr !== '0) begin miscompares++; $display("FAIL reset_row got rd=%b addr=%0d expected 0/0", row_rd, row_addr); end
      vectors++; if (result_bus !== '0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_result_busy got %h/%b expected 0/0", result_bus, busy); end
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      $display("txn reset released");
   endtask

   task automatic test_identity();
      logic [127:0] res; int lat;
      load_identity();
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ident_ready got %b expected 1", in_ready); end
      run_vec(pk16(1, 2, 3, 4), res, lat);
      vectors++; if (res !== pk32(1, 2, 3, 4)) begin miscompares++; $display("FAIL ident_result got %h expected %h", res, pk32(1, 2, 3, 4)); end
      vectors++; if (lat !== 5) begin miscompares++; $display("FAIL ident_latency got %0d expected 5", lat); end
      vectors++; if (addr_n !== 4) begin miscompares++; $display("FAIL ident_rd_count got %0d expected 4", addr_n); end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (addr_log[i] !== i) begin miscompares++; $display("FAIL ident_row_addr[%0d] got %0d expected %0d", i, addr_log[i], i); end
      end
      handshake();
      vectors++; if (busy !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL ident_idle got busy=%b ready=%b expected 0/1", busy, in_ready); end
   endtask

   task automatic test_signed();
      logic [127:0] res; int lat;
      for (int r = 0; r < N; r++) wmem[r] = pk16(1, -1, 2, -3);
      run_vec(pk16(-2, 3, 0, -1), res, lat);
      vectors++; if (res !== pk32(0, 0, 0, 0)) begin miscompares++; $display("FAIL signed_zero got %h expected %h", res, pk32(0, 0, 0, 0)); end
      handshake();
      wmem[0] = pk16(5, 5, 5, 5);
      for (int r = 1; r < N; r++) wmem[r] = '0;
      run_vec(pk16(-2, 3, 0, -1), res, lat);
      vectors++; if (res !== pk32(-10, -10, -10, -10)) begin miscompares++; $display("FAIL signed_row0 got %h expected %h", res, pk32(-10, -10, -10, -10)); end
      handshake();
      // Non-trivial mix: col j = sum_i A[i]*W[i][j]
      wmem[0] = pk16(1, 2, -3, 4);
      wmem[1] = pk16(-5, 6, 7, -8);
      wmem[2] = pk16(9, -10, 11, 12);
      wmem[3] = pk16(-13, 14, -15, 16);
      run_vec(pk16(2, -1, 3, -4), res, lat);
      // col0: 2+5+27+52=86 col1: 4-6-30-56=-88 col2: -6-7+33+60=80 col3: 8+8+36-64=-12
      vectors++; if (res !== pk32(86, -88, 80, -12)) begin miscompares++; $display("FAIL signed_mix got %h expected %h", res, pk32(86, -88, 80, -12)); end
      handshake();
   endtask

   task automatic test_wrap();
      logic [127:0] res; int lat;
      for (int r = 0; r < N; r++) wmem[r] = pk16(32767, 32767, 32767, 32767);
      run_vec(pk16(32767, 32767, 32767, 32767), res, lat);
      // 4*1073676289 = 4294705156 -> 0xFFFC0004 = -262140
      vectors++; if (res !== pk32(-262140, -262140, -262140, -262140)) begin miscompares++; $display("FAIL wrap got %h expected %h", res, pk32(-262140, -262140, -262140, -262140)); end
      handshake();
   endtask

   task automatic test_backpressure();
      logic [127:0] res; int lat; int bad;
      load_identity();
      out_ready = 1'b0;
      run_vec(pk16(1, 2, 3, 4), res, lat);
      vectors++; if (res !== pk32(1, 2, 3, 4)) begin miscompares++; $display("FAIL bp_result got %h expected %h", res, pk32(1, 2, 3, 4)); end
      in_valid = 1'b1;
      vectorA_bus = pk16(9, 9, 9, 9);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (result_bus !== pk32(1, 2, 3, 4) || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      vectors++; if (bad !== 0) begin miscompares++; $display("FAIL bp_hold got %0d bad cycles expected 0 (last res=%h ov=%b rdy=%b)", bad, result_bus, out_valid, in_ready); end
      in_valid = 1'b0;
      out_ready = 1'b1;
      handshake();
      vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL bp_release got rdy=%b ov=%b busy=%b expected 1/0/0", in_ready, out_valid, busy); end
      $display("txn backpressure released");
   endtask

   task automatic test_abort();
      logic [127:0] res; int lat; int seen;
      load_identity();
      vectorA_bus = pk16(7, 7, 7, 7);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      abort = 1'b1;
      #1;
      vectors++; if (row_rd !== 1'b0) begin miscompares++; $display("FAIL abort_row_rd got %b expected 0", row_rd); end
      @(posedge clk); #1;
      abort = 1'b0;
      vectors++; if (busy !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL abort_idle got busy=%b ready=%b expected 0/1", busy, in_ready); end
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort_no_valid got %0d valid cycles expected 0", seen); end
      $display("txn abort in RUN");
      run_vec(pk16(1, 2, 3, 4), res, lat);
      vectors++; if (res !== pk32(1, 2, 3, 4)) begin miscompares++; $display("FAIL abort_next got %h expected %h", res, pk32(1, 2, 3, 4)); end
      handshake();
   endtask

   task automatic test_reset_mid();
      logic [127:0] res; int lat;
      load_identity();
      vectorA_bus = pk16(3, 3, 3, 3);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (N) @(posedge clk);
      #1;
      vectors++; if (busy !== 1'b1 || row_rd !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_drain got busy=%b rd=%b ov=%b expected 1/0/0", busy, row_rd, out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0 || row_rd !== 1'b0 || out_valid !== 1'b0 || result_bus !== '0 || in_ready !== 1'b1) begin
         miscompares++; $display("FAIL mid_reset got busy=%b rd=%b ov=%b res=%h rdy=%b expected 0/0/0/0/1", busy, row_rd, out_valid, result_bus, in_ready);
      end
      #4;
      rst_n = 1'b1;
      @(posedge clk); #1;
      $display("txn reset during DRAIN");
      run_vec(pk16(1, 1, 1, 1), res, lat);
      vectors++; if (res !== pk32(1, 1, 1, 1)) begin miscompares++; $display("FAIL mid_recover got %h expected %h", res, pk32(1, 1, 1, 1)); end
      handshake();
   endtask

   initial begin
      test_reset();
      test_identity();
      test_signed();
      test_wrap();
      test_backpressure();
      test_abort();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
